// File: rtl/dma_burst_engine.sv
// Single-channel AXI memory-to-memory DMA: INCR read bursts staged in a FIFO, then replayed as write bursts.
// Define DMA_4KB_SPLIT_EN to additionally clip every burst at 4 KB page boundaries of source and destination.
module dma_burst_engine #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MAX_BURST = 16,
    parameter int RD_ID     = 0,
    parameter int WR_ID     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                DMAEN,
    input  logic [ADDR_W-1:0]   DMASRC,
    input  logic [ADDR_W-1:0]   DMADST,
    input  logic [31:0]         DMALEN,
    output logic                DMA_interrupt,
    output logic                DMA_err,
    output logic [ID_W-1:0]     M_AWID,
    output logic [ADDR_W-1:0]   M_AWAddr,
    output logic [7:0]          M_AWLen,
    output logic [2:0]          M_AWSize,
    output logic [1:0]          M_AWBurst,
    output logic                M_AWValid,
    input  logic                M_AWReady,
    output logic [DATA_W-1:0]   M_WData,
    output logic [DATA_W/8-1:0] M_WStrb,
    output logic                M_WLast,
    output logic                M_WValid,
    input  logic                M_WReady,
    input  logic [ID_W-1:0]     M_BID,
    input  logic [1:0]          M_BResp,
    input  logic                M_BValid,
    output logic                M_BReady,
    output logic [ID_W-1:0]     M_ARID,
    output logic [ADDR_W-1:0]   M_ARAddr,
    output logic [7:0]          M_ARLen,
    output logic [2:0]          M_ARSize,
    output logic [1:0]          M_ARBurst,
    output logic                M_ARValid,
    input  logic                M_ARReady,
    input  logic [ID_W-1:0]     M_RID,
    input  logic [DATA_W-1:0]   M_RData,
    input  logic [1:0]          M_RResp,
    input  logic                M_RLast,
    input  logic                M_RValid,
    output logic                M_RReady
);

    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int PTR_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int DEPTH = 1 << PTR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_RDATA,
        S_WADDR,
        S_WDATA,
        S_WRESP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  src_q, src_d;
    logic [ADDR_W-1:0]  dst_q, dst_d;
    logic [31:0]        rem_q, rem_d;
    logic [CNT_W-1:0]   blen_q, blen_d;
    logic [CNT_W-1:0]   rcnt_q, rcnt_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic               err_q, err_d;
    logic               irq_q, irq_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               push;
    logic [CNT_W-1:0]   lim;
    logic               w_last;
`ifdef DMA_4KB_SPLIT_EN
    logic [31:0]        pg_src;
    logic [31:0]        pg_dst;
`endif

    // IDs are not checked; the response always belongs to the single outstanding burst.
    logic               id_unused;
    assign id_unused = ^{M_RID, M_BID};

    assign w_last = (wcnt_q == blen_q - CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        blen_d   = blen_q;
        rcnt_d   = rcnt_q;
        wcnt_d   = wcnt_q;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (DMAEN) begin
                    src_d   = DMASRC;
                    dst_d   = DMADST;
                    rem_d   = DMALEN;
                    err_d   = 1'b0;
                    state_d = (DMALEN == 32'd0) ? S_DONE : S_RADDR;
                end
            end
            S_RADDR: begin
                if (M_ARReady) state_d = S_RDATA;
            end
            S_RDATA: begin
                if (M_RValid) begin
                    push     = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rcnt_d   = rcnt_q + CNT_W'(1);
                    if (M_RResp != 2'b00) err_d = 1'b1;
                    // A missing RLast must not wedge the engine: the beat count closes the burst too.
                    if (M_RLast || rcnt_d == blen_q) begin
                        state_d = S_WADDR;
                        wcnt_d  = '0;
                    end
                end
            end
            S_WADDR: begin
                if (M_AWReady) state_d = S_WDATA;
            end
            S_WDATA: begin
                if (M_WReady) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    wcnt_d   = wcnt_q + CNT_W'(1);
                    if (w_last) state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (M_BValid) begin
                    if (M_BResp != 2'b00) err_d = 1'b1;
                    src_d   = src_q + (ADDR_W'(blen_q) << SIZE);
                    dst_d   = dst_q + (ADDR_W'(blen_q) << SIZE);
                    rem_d   = rem_q - 32'(blen_q);
                    state_d = (rem_d != 32'd0 && !err_d) ? S_RADDR : S_DONE;
                end
            end
            S_DONE: begin
                if (!DMAEN) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Burst length is fixed from the already-updated src/dst/rem whenever RADDR is entered.
        lim = (rem_d > 32'(MAX_BURST)) ? CNT_W'(MAX_BURST) : rem_d[CNT_W-1:0];
`ifdef DMA_4KB_SPLIT_EN
        pg_src = (32'd4096 - {20'd0, src_d[11:0]}) >> SIZE;
        pg_dst = (32'd4096 - {20'd0, dst_d[11:0]}) >> SIZE;
        if (pg_src < 32'(lim)) lim = pg_src[CNT_W-1:0];
        if (pg_dst < 32'(lim)) lim = pg_dst[CNT_W-1:0];
`endif
        if (state_d == S_RADDR && state_q != S_RADDR) begin
            blen_d   = lim;
            rcnt_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        irq_d   = (state_q == S_DONE) && DMAEN;
        // W data is a register fed by the next head, so consecutive beats leave no bubble.
        wdata_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            blen_q   <= '0;
            rcnt_q   <= '0;
            wcnt_q   <= '0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            blen_q   <= blen_d;
            rcnt_q   <= rcnt_d;
            wcnt_q   <= wcnt_d;
            err_q    <= err_d;
            irq_q    <= irq_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= M_RData;
    end

    assign DMA_interrupt = irq_q;
    assign DMA_err       = err_q;

    assign M_ARID    = ID_W'(RD_ID);
    assign M_ARAddr  = src_q;
    assign M_ARLen   = 8'(blen_q - CNT_W'(1));
    assign M_ARSize  = 3'(SIZE);
    assign M_ARBurst = 2'b01;
    assign M_ARValid = (state_q == S_RADDR);
    assign M_RReady  = (state_q == S_RDATA);

    assign M_AWID    = ID_W'(WR_ID);
    assign M_AWAddr  = dst_q;
    assign M_AWLen   = 8'(blen_q - CNT_W'(1));
    assign M_AWSize  = 3'(SIZE);
    assign M_AWBurst = 2'b01;
    assign M_AWValid = (state_q == S_WADDR);

    assign M_WData   = wdata_q;
    assign M_WStrb   = '1;
    assign M_WValid  = (state_q == S_WDATA);
    assign M_WLast   = (state_q == S_WDATA) && w_last;
    assign M_BReady  = (state_q == S_WRESP);

endmodule

// File: tb/tb_dma_burst_engine.sv
// Self-checking bench for dma_burst_engine: randomized AXI slave with memory, burst log and a burst-planning model.
module tb_dma_burst_engine;

    localparam int MB = 16;

    logic        clk, rst, DMAEN;
    logic [31:0] DMASRC, DMADST, DMALEN;
    logic        DMA_interrupt, DMA_err;
    logic [3:0]  M_AWID, M_ARID, M_BID, M_RID;
    logic [31:0] M_AWAddr, M_ARAddr, M_WData, M_RData;
    logic [7:0]  M_AWLen, M_ARLen;
    logic [2:0]  M_AWSize, M_ARSize;
    logic [1:0]  M_AWBurst, M_ARBurst, M_BResp, M_RResp;
    logic        M_AWValid, M_AWReady, M_ARValid, M_ARReady;
    logic [3:0]  M_WStrb;
    logic        M_WLast, M_WValid, M_WReady;
    logic        M_BValid, M_BReady;
    logic        M_RLast, M_RValid, M_RReady;

    dma_burst_engine dut (
        .clk(clk), .rst(rst), .DMAEN(DMAEN), .DMASRC(DMASRC), .DMADST(DMADST), .DMALEN(DMALEN),
        .DMA_interrupt(DMA_interrupt), .DMA_err(DMA_err),
        .M_AWID(M_AWID), .M_AWAddr(M_AWAddr), .M_AWLen(M_AWLen), .M_AWSize(M_AWSize),
        .M_AWBurst(M_AWBurst), .M_AWValid(M_AWValid), .M_AWReady(M_AWReady),
        .M_WData(M_WData), .M_WStrb(M_WStrb), .M_WLast(M_WLast), .M_WValid(M_WValid), .M_WReady(M_WReady),
        .M_BID(M_BID), .M_BResp(M_BResp), .M_BValid(M_BValid), .M_BReady(M_BReady),
        .M_ARID(M_ARID), .M_ARAddr(M_ARAddr), .M_ARLen(M_ARLen), .M_ARSize(M_ARSize),
        .M_ARBurst(M_ARBurst), .M_ARValid(M_ARValid), .M_ARReady(M_ARReady),
        .M_RID(M_RID), .M_RData(M_RData), .M_RResp(M_RResp), .M_RLast(M_RLast),
        .M_RValid(M_RValid), .M_RReady(M_RReady)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          idx;
    } burst_t;

    burst_t      rq[$], wq[$];
    int          bq[$];
    logic [31:0] ar_addr_log[$], aw_addr_log[$];
    int          ar_len_log[$], aw_len_log[$];
    logic [31:0] wmem [logic [31:0]];
    int          ar_idx, aw_idx, r_beat, w_beat;
    int          err_r_idx = -1, err_b_idx = -1;
    bit          stall = 0;
    logic [31:0] seed = 32'h1234_5678;

    function automatic logic [31:0] srcword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic bit go();
        return !stall || ($urandom_range(0, 3) != 0);
    endfunction

    // AXI slave: all decisions are made at the negedge for the following posedge.
    bit          ar_pend, aw_pend, w_pend, r_taken, b_taken;
    logic [31:0] ar_pa, aw_pa, w_pd;
    logic [7:0]  ar_pl, aw_pl;
    logic        w_pl;
    initial begin
        M_ARReady = 0; M_AWReady = 0; M_WReady = 0;
        M_RValid = 0; M_RData = 0; M_RResp = 0; M_RLast = 0; M_RID = 0;
        M_BValid = 0; M_BResp = 0; M_BID = 4'd4;
        forever begin
            @(negedge clk);
            if (rst) begin
                M_ARReady = 0; M_AWReady = 0; M_WReady = 0; M_RValid = 0; M_BValid = 0;
                rq.delete(); wq.delete(); bq.delete();
                r_beat = 0; w_beat = 0;
                ar_pend = 0; aw_pend = 0; w_pend = 0; r_taken = 0; b_taken = 0;
                continue;
            end
            if (ar_pend) begin
                n_checks++;
                if (!(M_ARValid && M_ARAddr == ar_pa && M_ARLen == ar_pl)) begin
                    n_fail++;
                    $display("FAIL ar_stable: valid=%0b addr=%h len=%0d, required valid=1 addr=%h len=%0d",
                             M_ARValid, M_ARAddr, M_ARLen, ar_pa, ar_pl);
                end
            end
            if (aw_pend) begin
                n_checks++;
                if (!(M_AWValid && M_AWAddr == aw_pa && M_AWLen == aw_pl)) begin
                    n_fail++;
                    $display("FAIL aw_stable: valid=%0b addr=%h len=%0d, required valid=1 addr=%h len=%0d",
                             M_AWValid, M_AWAddr, M_AWLen, aw_pa, aw_pl);
                end
            end
            if (w_pend) begin
                n_checks++;
                if (!(M_WValid && M_WData == w_pd && M_WLast == w_pl)) begin
                    n_fail++;
                    $display("FAIL w_stable: valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b",
                             M_WValid, M_WData, M_WLast, w_pd, w_pl);
                end
            end
            // B: presented only after the last W beat has completed
            if (b_taken) begin M_BValid = 0; void'(bq.pop_front()); end
            if (!M_BValid && bq.size() > 0 && go()) begin
                M_BValid = 1;
                M_BResp  = (bq[0] == err_b_idx) ? 2'b10 : 2'b00;
            end
            b_taken = M_BValid && M_BReady;
            // R
            if (r_taken) begin
                M_RValid = 0;
                r_beat++;
                if (r_beat == rq[0].len) begin void'(rq.pop_front()); r_beat = 0; end
            end
            if (!M_RValid && rq.size() > 0 && go()) begin
                M_RValid = 1;
                M_RData  = srcword(rq[0].addr + 32'(4 * r_beat));
                M_RLast  = (r_beat == rq[0].len - 1);
                M_RResp  = (rq[0].idx == err_r_idx && r_beat == 0) ? 2'b10 : 2'b00;
            end
            r_taken = M_RValid && M_RReady;
            // AR
            M_ARReady = go();
            ar_pend = M_ARValid && !M_ARReady; ar_pa = M_ARAddr; ar_pl = M_ARLen;
            if (M_ARValid && M_ARReady) begin
                ar_addr_log.push_back(M_ARAddr);
                ar_len_log.push_back(int'(M_ARLen));
                rq.push_back('{M_ARAddr, int'(M_ARLen) + 1, ar_idx});
                ar_idx++;
                n_checks++;
                if (M_ARSize !== 3'd2 || M_ARBurst !== 2'b01 || M_ARID !== 4'd0) begin
                    n_fail++;
                    $display("FAIL ar_attr: size=%0d burst=%0d id=%0d, required 2/1/0", M_ARSize, M_ARBurst, M_ARID);
                end
            end
            // AW
            M_AWReady = go();
            aw_pend = M_AWValid && !M_AWReady; aw_pa = M_AWAddr; aw_pl = M_AWLen;
            if (M_AWValid && M_AWReady) begin
                aw_addr_log.push_back(M_AWAddr);
                aw_len_log.push_back(int'(M_AWLen));
                wq.push_back('{M_AWAddr, int'(M_AWLen) + 1, aw_idx});
                aw_idx++;
                n_checks++;
                if (M_AWSize !== 3'd2 || M_AWBurst !== 2'b01 || M_AWID !== 4'd4) begin
                    n_fail++;
                    $display("FAIL aw_attr: size=%0d burst=%0d id=%0d, required 2/1/4", M_AWSize, M_AWBurst, M_AWID);
                end
            end
            // W
            M_WReady = go();
            w_pend = M_WValid && !M_WReady; w_pd = M_WData; w_pl = M_WLast;
            if (M_WValid && M_WReady) begin
                n_checks++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL w_order: W beat with no accepted AW, required none");
                end else begin
                    if (M_WLast !== (w_beat == wq[0].len - 1) || M_WStrb !== 4'hF) begin
                        n_fail++;
                        $display("FAIL w_last_strb: beat=%0d last=%0b strb=%h, required last=%0b strb=f",
                                 w_beat, M_WLast, M_WStrb, (w_beat == wq[0].len - 1));
                    end
                    wmem[wq[0].addr + 32'(4 * w_beat)] = M_WData;
                    w_beat++;
                    if (w_beat == wq[0].len) begin
                        bq.push_back(wq[0].idx);
                        void'(wq.pop_front());
                        w_beat = 0;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1; DMAEN = 0; DMASRC = 0; DMADST = 0; DMALEN = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({M_ARValid, M_AWValid, M_WValid, M_WLast, M_RReady, M_BReady, DMA_interrupt, DMA_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: ar/aw/w/wl/rr/br/irq/err=%b, required 00000000",
                     {M_ARValid, M_AWValid, M_WValid, M_WLast, M_RReady, M_BReady, DMA_interrupt, DMA_err});
        end
        n_checks++;
        if (M_ARAddr !== 32'h0 || M_AWAddr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr: araddr=%h awaddr=%h, required 0/0", M_ARAddr, M_AWAddr);
        end
        rst = 0;
        @(negedge clk);
    endtask

    // Drive one transfer, then compare bursts, payload, error and interrupt handshake with the burst model.
    task automatic transfer_scenario(input string tag, input logic [31:0] s0, input logic [31:0] d0,
                                     input int len, input int er, input int eb, input bit st);
        logic [31:0] es[$], ed[$];
        int          en[$];
        logic [31:0] s, d;
        int          rem, k, n, words, t, pg;
        bit          exp_err;
        s = s0; d = d0; rem = len; k = 0; words = 0; exp_err = 0;
        while (rem > 0) begin
            n = (rem < MB) ? rem : MB;
`ifdef DMA_4KB_SPLIT_EN
            pg = (4096 - int'(s & 32'hFFF)) / 4; if (pg < n) n = pg;
            pg = (4096 - int'(d & 32'hFFF)) / 4; if (pg < n) n = pg;
`endif
            es.push_back(s); ed.push_back(d); en.push_back(n);
            words += n; s += 32'(n * 4); d += 32'(n * 4); rem -= n;
            if (k == er || k == eb) begin exp_err = 1; break; end
            k++;
        end
        ar_addr_log.delete(); ar_len_log.delete(); aw_addr_log.delete(); aw_len_log.delete();
        wmem.delete();
        ar_idx = 0; aw_idx = 0; err_r_idx = er; err_b_idx = eb; stall = st;
        seed = $urandom;
        DMASRC = s0; DMADST = d0; DMALEN = 32'(len); DMAEN = 1;
        t = 0;
        while (!DMA_interrupt && t < 8000) begin @(negedge clk); t++; end
        n_checks++;
        if (!DMA_interrupt) begin
            n_fail++;
            $display("FAIL %s_done: interrupt=0 after %0d cycles, required 1", tag, t);
        end
        n_checks++;
        if (ar_len_log.size() != en.size() || aw_len_log.size() != en.size()) begin
            n_fail++;
            $display("FAIL %s_nbursts: ar=%0d aw=%0d, required %0d", tag, ar_len_log.size(), aw_len_log.size(), en.size());
        end
        for (int i = 0; i < en.size() && i < ar_len_log.size() && i < aw_len_log.size(); i++) begin
            n_checks++;
            if (ar_addr_log[i] !== es[i] || ar_len_log[i] != en[i] - 1 ||
                aw_addr_log[i] !== ed[i] || aw_len_log[i] != en[i] - 1) begin
                n_fail++;
                $display("FAIL %s_burst%0d: ar=%h/%0d aw=%h/%0d, required ar=%h/%0d aw=%h/%0d", tag, i,
                         ar_addr_log[i], ar_len_log[i], aw_addr_log[i], aw_len_log[i], es[i], en[i] - 1, ed[i], en[i] - 1);
            end
        end
        n_checks++;
        if (wmem.size() != words) begin
            n_fail++;
            $display("FAIL %s_nwords: written=%0d, required %0d", tag, wmem.size(), words);
        end
        for (int i = 0; i < words; i++) begin
            logic [31:0] a;
            a = d0 + 32'(4 * i);
            n_checks++;
            if (!wmem.exists(a) || wmem[a] !== srcword(s0 + 32'(4 * i))) begin
                n_fail++;
                $display("FAIL %s_data%0d: addr=%h got=%h, required %h", tag, i, a,
                         wmem.exists(a) ? wmem[a] : 32'hx, srcword(s0 + 32'(4 * i)));
            end
        end
        n_checks++;
        if (DMA_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s_err: DMA_err=%0b, required %0b", tag, DMA_err, exp_err);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (DMA_interrupt !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_irq_hold: interrupt=%0b while DMAEN=1, required 1", tag, DMA_interrupt);
        end
        DMAEN = 0;
        @(negedge clk);
        n_checks++;
        if (DMA_interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_irq_clear: interrupt=%0b one cycle after DMAEN=0, required 0", tag, DMA_interrupt);
        end
        stall = 0; err_r_idx = -1; err_b_idx = -1;
        @(negedge clk);
    endtask

    task automatic test_single_burst();
        transfer_scenario("single", 32'h1000, 32'h2000, 16, -1, -1, 0);
        n_checks++;
        if (ar_len_log.size() != 1 || ar_len_log[0] != 15 || aw_addr_log.size() != 1 || aw_addr_log[0] !== 32'h2000) begin
            n_fail++;
            $display("FAIL single_shape: ars=%0d, required one AR len 15 and one AW at 2000", ar_len_log.size());
        end
    endtask

    task automatic test_multi_burst();
        transfer_scenario("multi", 32'h1000, 32'h2000, 37, -1, -1, 0);
        n_checks++;
        if (ar_len_log.size() != 3 || ar_len_log[2] != 4 || ar_addr_log[1] !== 32'h1040 || aw_addr_log[2] !== 32'h2080) begin
            n_fail++;
            $display("FAIL multi_shape: ars=%0d, required lens 15,15,4 at 1000,1040,1080", ar_len_log.size());
        end
    endtask

    task automatic test_zero_len();
        bit got;
        ar_addr_log.delete(); aw_addr_log.delete(); ar_len_log.delete(); aw_len_log.delete();
        DMASRC = 32'h100; DMADST = 32'h200; DMALEN = 0; DMAEN = 1;
        got = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (DMA_interrupt) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL zero_irq: interrupt not seen within 2 cycles, required 1");
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (ar_addr_log.size() != 0 || aw_addr_log.size() != 0 || DMA_err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_quiet: ars=%0d aws=%0d err=%0b, required 0/0/0", ar_addr_log.size(), aw_addr_log.size(), DMA_err);
        end
        DMAEN = 0;
        @(negedge clk);
        n_checks++;
        if (DMA_interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_irq_clear: interrupt=%0b, required 0", DMA_interrupt);
        end
        @(negedge clk);
    endtask

    task automatic test_errors();
        transfer_scenario("bresp", 32'h4000, 32'h5000, 32, -1, 0, 0);
        transfer_scenario("rresp", 32'h4100, 32'h5100, 40, 1, -1, 1);
    endtask

    task automatic test_random_stall();
        transfer_scenario("stall50", $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, 50, -1, -1, 1);
        for (int i = 0; i < 3; i++)
            transfer_scenario("rand", $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                              int'($urandom_range(1, 70)), -1, -1, 1);
    endtask

    task automatic test_4kb_split();
        int exp0;
`ifdef DMA_4KB_SPLIT_EN
        exp0 = 1;
`else
        exp0 = 15;
`endif
        transfer_scenario("split", 32'h0FF8, 32'h3000, 16, -1, -1, 0);
        n_checks++;
        if (ar_len_log.size() == 0 || ar_len_log[0] != exp0) begin
            n_fail++;
            $display("FAIL split_first: first ARLen=%0d, required %0d", ar_len_log.size() ? ar_len_log[0] : -1, exp0);
        end
    endtask

    task automatic test_back_to_back();
        transfer_scenario("b2b_err", 32'h8000, 32'h9000, 20, -1, 1, 0);
        transfer_scenario("b2b_wrap", 32'hFFFF_FFC0, 32'hFFFF_FF80, 32, -1, -1, 1);
    endtask

    task automatic test_reset_mid();
        int t, nar, naw, nw;
        bit active;
        ar_addr_log.delete(); aw_addr_log.delete(); ar_len_log.delete(); aw_len_log.delete();
        wmem.delete(); ar_idx = 0; aw_idx = 0;
        DMASRC = 32'h6000; DMADST = 32'h7000; DMALEN = 60; DMAEN = 1;
        t = 0;
        while (aw_addr_log.size() < 2 && t < 1000) begin @(negedge clk); t++; end
        n_checks++;
        if (aw_addr_log.size() < 2) begin
            n_fail++;
            $display("FAIL rstmid_progress: aws=%0d, required 2", aw_addr_log.size());
        end
        @(negedge clk);
        rst = 1; DMAEN = 0;
        @(negedge clk);
        rst = 0;
        nar = ar_addr_log.size(); naw = aw_addr_log.size(); nw = wmem.size();
        active = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (M_ARValid | M_AWValid | M_WValid | M_RReady | M_BReady | DMA_interrupt | DMA_err) active = 1;
        end
        n_checks++;
        if (active || ar_addr_log.size() != nar || aw_addr_log.size() != naw || wmem.size() != nw) begin
            n_fail++;
            $display("FAIL rstmid_quiet: active=%0b ar %0d->%0d aw %0d->%0d, required no activity",
                     active, nar, ar_addr_log.size(), naw, aw_addr_log.size());
        end
        transfer_scenario("post_rst", 32'h6000, 32'h7800, 20, -1, -1, 0);
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_multi_burst();
        test_zero_len();
        test_errors();
        test_random_stall();
        test_4kb_split();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_burst_engine.md
Name: dma_burst_engine

Overview:
- Parametrised single-channel memory-to-memory DMA master and the next generation of the CPU-programmed DMA.
- Copies DMALEN 32-bit words from DMASRC to DMADST as AXI INCR read bursts followed by write bursts, staged in an internal FIFO.
- Sizes each burst to the words remaining (variable AxLEN), reports AXI error responses, and holds its interrupt until software clears DMAEN.
- Sits between the CPU-side DMA register slave and one AXI master port of the interconnect.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; word = DATA_W/8 bytes.
- ID_W, 4, AXI ID width.
- MAX_BURST, 16, maximum beats per burst and FIFO depth; power of two, 1..256.
- RD_ID, 0, ARID value.
- WR_ID, 4, AWID value.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- DMAEN  in  1  start/hold; 0 clears completion.
- DMASRC  in  ADDR_W  source byte address, word aligned.
- DMADST  in  ADDR_W  destination byte address, word aligned.
- DMALEN  in  32  transfer length in words.
- DMA_interrupt  out  1  completion interrupt.
- DMA_err  out  1  sticky: an RRESP or BRESP was non-OKAY.
- M_AWID/M_AWAddr/M_AWLen/M_AWSize/M_AWBurst/M_AWValid  out  ID_W/ADDR_W/8/3/2/1; M_AWReady in 1.
- M_WData/M_WStrb/M_WLast/M_WValid  out  DATA_W/DATA_W/8/1/1; M_WReady in 1.
- M_BID/M_BResp/M_BValid  in  ID_W/2/1; M_BReady out 1.
- M_ARID/M_ARAddr/M_ARLen/M_ARSize/M_ARBurst/M_ARValid  out  ID_W/ADDR_W/8/3/2/1; M_ARReady in 1.
- M_RID/M_RData/M_RResp/M_RLast/M_RValid  in  ID_W/DATA_W/2/1/1; M_RReady out 1.

Behaviour:
- Reset: state IDLE; all Valid/Ready/Last outputs, DMA_interrupt and DMA_err 0; address and count registers 0; FIFO empty. Reset mid-transfer abandons the transfer immediately with no further AXI beats.
- States: IDLE -> RADDR -> RDATA -> WADDR -> WDATA -> WRESP -> (RADDR | DONE); DONE -> IDLE.
- IDLE: when DMAEN=1, latch src, dst and rem=DMALEN; clear DMA_err. If DMALEN=0 go to DONE, else go to RADDR.
- Burst size: blen = min(rem, MAX_BURST), computed on entry to RADDR and held through WRESP. AxLEN = blen-1; AxSize = log2(DATA_W/8); AxBurst = INCR.
- RADDR: M_ARValid=1, ARAddr=src, stable until M_ARReady; then go to RDATA.
- RDATA: M_RReady=1. Each beat with M_RValid pushes RData into the FIFO. On the beat with RLast go to WADDR. A beat count reaching blen without RLast is also treated as last.
- WADDR: M_AWValid=1, AWAddr=dst, held until M_AWReady; then go to WDATA.
- WDATA: M_WValid=1 and WData = FIFO head, registered, with no bubble between beats. The head pops on WValid&WReady. WStrb is all ones. WLast=1 exactly on beat blen. After the last beat go to WRESP.
- WRESP: M_BReady=1. On BValid: src += blen*bytes, dst += blen*bytes, rem -= blen. Go to RADDR if rem!=0 and DMA_err=0, else go to DONE.
- Errors: any RResp or BResp != 0 sets DMA_err. The current burst still completes (all beats accepted, W burst still issued); the transfer then stops at WRESP.
- DONE: DMA_interrupt=1, registered one cycle after entry. Stays in DONE until DMAEN=0, then goes to IDLE with DMA_interrupt=0 the next cycle.
- DMAEN falling mid-transfer is ignored until DONE.
- The FIFO never overflows, because a read burst is never issued until the FIFO is empty.
- Address arithmetic wraps modulo 2^ADDR_W.
- RID/BID are not checked.

Optional Feature:
- DMA_4KB_SPLIT_EN defined: blen = min(rem, MAX_BURST, words to the next 4 KB boundary of src, words to the next 4 KB boundary of dst). No burst ever crosses a 4 KB page.
- Not defined: blen = min(rem, MAX_BURST), with no boundary check.

Test Plan:
- DMALEN=16, MAX_BURST=16, src=0x1000, dst=0x2000, zero-wait slave -> one AR (len 15), 16 R, one AW (len 15) at 0x2000, 16 W with data in order and WLast on beat 16; interrupt asserted, DMA_err=0.
- DMALEN=37 -> bursts of 16, 16, 5 words (AxLEN 15, 15, 4); addresses step by 0x40; destination memory equals source.
- DMALEN=0, DMAEN=1 -> no AXI activity; DMA_interrupt=1 within 2 cycles; DMAEN=0 -> interrupt=0 the next cycle.
- BResp=2 on the first burst of DMALEN=32 -> DMA_err=1, DONE after that burst, no second AR issued.
- Random Ready/Valid stalls on all channels, DMALEN=50 -> payload unchanged, Valid never dropped before handshake, data held stable while stalled.
- With DMA_4KB_SPLIT_EN: src=0x0FF8, DMALEN=16 -> bursts of 2 then 14 words.
